// File: rtl/ecs_rx_param_if.sv
// Receive-side bundle of the ECS pulse-count receiver: the output word
// handshake plus busy/error/overrun status.
interface ecs_rx_param_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              rx_busy;
    logic              rx_err;
    logic              rx_ovr;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_busy,
        output rx_err,
        output rx_ovr,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_busy,
        input  rx_err,
        input  rx_ovr,
        output rx_ready
    );
endinterface

// File: rtl/ecs_rx_param.sv
// Parametrised single-wire pulse-count receiver: bursts of rising edges encode
// per-segment set-bit indices. Optional abort of idle partial frames: ECS_RX_TIMEOUT_EN.
module ecs_rx_param #(
    parameter int unsigned SEG_W      = 8,
    parameter int unsigned NSEG       = 2,
    parameter int unsigned GAP_CYCLES = 8,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          ECS_In,
    ecs_rx_param_if.master rx
);
    localparam int unsigned MAXN   = SEG_W / 2;
    localparam int unsigned DATA_W = SEG_W * NSEG;
    localparam int unsigned PW     = $clog2(SEG_W + MAXN + 2);
    localparam int unsigned SW     = (NSEG > 1) ? $clog2(NSEG) : 1;

    localparam logic [PW-1:0] HDR_MAX  = PW'(2 * MAXN + 2);
    localparam logic [PW-1:0] MAXN_P   = PW'(MAXN);
    localparam logic [PW-1:0] INV_OFS  = PW'(MAXN + 1);
    localparam logic [PW-1:0] SEGW_P   = PW'(SEG_W);
    localparam logic [7:0]    GAP_HIT  = 8'(GAP_CYCLES);
    localparam logic [SW-1:0] SEG_LAST = SW'(NSEG - 1);

    typedef enum logic {S_HDR, S_IDX} state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [7:0]        gap_q, gap_d;
    logic [PW-1:0]     n_q, n_d;
    logic [PW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     last_q, last_d;
    logic              inv_q, inv_d;
    logic [SEG_W-1:0]  acc_q, acc_d;
    logic [SW-1:0]     seg_q, seg_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              ovr_q, ovr_d;

    logic              ev, burst_end, seg_done, seg_err, frame_done, hs;
    logic [PW-1:0]     hv, idx;
    logic [SEG_W-1:0]  seg_val;

`ifdef ECS_RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] to_q, to_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    always_comb begin
        sync1_d = ECS_In;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        ev      = sync2_q & ~sync3_q;

        gap_d = ev ? '0 : ((gap_q == '1) ? gap_q : gap_q + 8'd1);
        // A coincident edge keeps the burst open.
        burst_end = !ev && (gap_q == GAP_HIT) && (pcnt_q != '0);

        pcnt_d = pcnt_q;
        if (burst_end)
            pcnt_d = '0;
        else if (ev && pcnt_q != '1)
            pcnt_d = pcnt_q + PW'(1);

        state_d    = state_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        inv_d      = inv_q;
        acc_d      = acc_q;
        seg_d      = seg_q;
        asm_d      = asm_q;
        data_d     = data_q;
        valid_d    = valid_q;
        busy_d     = busy_q | ev;
        err_d      = 1'b0;
        ovr_d      = 1'b0;
        seg_done   = 1'b0;
        seg_err    = 1'b0;
        frame_done = 1'b0;
        seg_val    = '0;
        hv         = pcnt_q - PW'(1);
        idx        = pcnt_q - PW'(1);
        hs         = valid_q & rx.rx_ready;

        if (burst_end) begin
            case (state_q)
                S_HDR: begin
                    if (pcnt_q > HDR_MAX) begin
                        seg_err = 1'b1;
                    end else begin
                        if (hv > MAXN_P) begin
                            inv_d = 1'b1;
                            n_d   = hv - INV_OFS;
                        end else begin
                            inv_d = 1'b0;
                            n_d   = hv;
                        end
                        acc_d = '0;
                        cnt_d = '0;
                        if (n_d == '0)
                            seg_done = 1'b1;
                        else
                            state_d = S_IDX;
                    end
                end
                S_IDX: begin
                    if (pcnt_q > SEGW_P || (cnt_q != '0 && idx <= last_q)) begin
                        seg_err = 1'b1;
                    end else begin
                        acc_d  = acc_q | (SEG_W'(1) << idx);
                        last_d = idx;
                        cnt_d  = cnt_q + PW'(1);
                        if (cnt_d == n_q)
                            seg_done = 1'b1;
                    end
                end
                default: seg_err = 1'b1;
            endcase
        end

`ifdef ECS_RX_TIMEOUT_EN
        to_d = (ev || !busy_q) ? '0 : ((to_q == '1) ? to_q : to_q + TW'(1));
        if (busy_q && !ev && to_q == TO_LAST)
            seg_err = 1'b1;
`endif

        if (seg_err) begin
            err_d   = 1'b1;
            state_d = S_HDR;
            seg_d   = '0;
            busy_d  = 1'b0;
            asm_d   = '0;
            pcnt_d  = '0;
        end else if (seg_done) begin
            seg_val = acc_d ^ {SEG_W{inv_d}};
            state_d = S_HDR;
            for (int unsigned s = 0; s < NSEG; s++) begin
                if (SW'(s) == seg_q)
                    asm_d[s*SEG_W +: SEG_W] = seg_val;
            end
            if (seg_q == SEG_LAST) begin
                frame_done = 1'b1;
                seg_d      = '0;
                busy_d     = 1'b0;
            end else begin
                seg_d = seg_q + SW'(1);
            end
        end

        // A completing frame may reuse the slot being handed off this cycle.
        if (frame_done) begin
            if (!valid_q || hs) begin
                data_d  = asm_d;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (hs) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= S_HDR;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            pcnt_q  <= '0;
            gap_q   <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            inv_q   <= 1'b0;
            acc_q   <= '0;
            seg_q   <= '0;
            asm_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef ECS_RX_TIMEOUT_EN
            to_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
            pcnt_q  <= pcnt_d;
            gap_q   <= gap_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            inv_q   <= inv_d;
            acc_q   <= acc_d;
            seg_q   <= seg_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
`ifdef ECS_RX_TIMEOUT_EN
            to_q    <= to_d;
`endif
        end
    end

    assign rx.rx_data  = data_q;
    assign rx.rx_valid = valid_q;
    assign rx.rx_busy  = busy_q;
    assign rx.rx_err   = err_q;
    assign rx.rx_ovr   = ovr_q;
endmodule

// File: tb/tb_ecs_rx_param.sv
// Directed bench for ecs_rx_param (SEG_W=8, NSEG=2, GAP_CYCLES=8, TIMEOUT=64).
module tb_ecs_rx_param;
    logic clk = 1'b0;
    logic RST;
    logic ECS_In;

    int checks = 0;
    int errors = 0;

    int unsigned err_seen = 0, ovr_seen = 0, vrise = 0, vhigh = 0;
    logic        vprev = 1'b0;
    logic [15:0] last_word = '0;
    int unsigned e0, o0, r0, h0;

    ecs_rx_param_if #(.DATA_W(16)) rx ();

    ecs_rx_param #(
        .SEG_W      (8),
        .NSEG       (2),
        .GAP_CYCLES (8),
        .TIMEOUT    (64)
    ) dut (
        .clk    (clk),
        .RST    (RST),
        .ECS_In (ECS_In),
        .rx     (rx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx.rx_err === 1'b1) err_seen++;
        if (rx.rx_ovr === 1'b1) ovr_seen++;
        if (rx.rx_valid === 1'b1) vhigh++;
        if (rx.rx_valid === 1'b1 && vprev !== 1'b1) begin
            vrise++;
            last_word = rx.rx_data;
        end
        vprev = rx.rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic burst(input int n);
        repeat (n) begin
            ECS_In = 1'b1;
            tick(2);
            ECS_In = 1'b0;
            tick(2);
        end
        tick(12);
    endtask

    task automatic snap();
        e0 = err_seen; o0 = ovr_seen; r0 = vrise; h0 = vhigh;
    endtask

    task automatic send_0312();
        burst(3); burst(2); burst(5);
        burst(3); burst(1); burst(2);
    endtask

    task automatic send_00fe();
        burst(7); burst(1);
        burst(1);
    endtask

    initial begin
        RST = 1'b1;
        ECS_In = 1'b0;
        rx.rx_ready = 1'b1;
        tick(3);
        check("reset_valid", {31'd0, rx.rx_valid}, 32'd0);
        check("reset_data",  {16'd0, rx.rx_data},  32'd0);
        check("reset_busy",  {31'd0, rx.rx_busy},  32'd0);
        check("reset_err",   {31'd0, rx.rx_err},   32'd0);
        check("reset_ovr",   {31'd0, rx.rx_ovr},   32'd0);
        RST = 1'b0;
        tick(4);

        // 0x0312 with consumer always ready
        snap();
        burst(3); burst(2); burst(5);
        check("busy_mid_frame", {31'd0, rx.rx_busy}, 32'd1);
        burst(3); burst(1); burst(2);
        tick(4);
        check("f0312_pulses", vrise - r0, 32'd1);
        check("f0312_word", {16'd0, last_word}, 32'h0312);
        check("f0312_vcycles", vhigh - h0, 32'd1);
        check("f0312_busy", {31'd0, rx.rx_busy}, 32'd0);
        check("f0312_valid", {31'd0, rx.rx_valid}, 32'd0);

        // Inverted segment and all-ones
        snap();
        send_00fe();
        tick(4);
        check("f00fe_pulses", vrise - r0, 32'd1);
        check("f00fe_word", {16'd0, last_word}, 32'h00FE);
        snap();
        burst(6); burst(6);
        tick(4);
        check("fffff_word", {16'd0, last_word}, 32'hFFFF);
        check("fffff_err", err_seen - e0, 32'd0);

        // Header out of range
        snap();
        burst(11);
        tick(2);
        check("hdr11_err", err_seen - e0, 32'd1);
        check("hdr11_busy", {31'd0, rx.rx_busy}, 32'd0);
        // Non-ascending indices
        snap();
        burst(3); burst(5); burst(3);
        tick(2);
        check("desc_idx_err", err_seen - e0, 32'd1);
        check("desc_idx_novalid", vrise - r0, 32'd0);
        snap();
        send_0312();
        tick(4);
        check("after_err_word", {16'd0, last_word}, 32'h0312);
        check("after_err_pulses", vrise - r0, 32'd1);

        // Backpressure and overrun
        rx.rx_ready = 1'b0;
        snap();
        send_0312();
        send_00fe();
        tick(4);
        check("bp_ovr", ovr_seen - o0, 32'd1);
        check("bp_valid", {31'd0, rx.rx_valid}, 32'd1);
        check("bp_data", {16'd0, rx.rx_data}, 32'h0312);
        check("bp_pulses", vrise - r0, 32'd1);
        rx.rx_ready = 1'b1;
        tick(1);
        rx.rx_ready = 1'b0;
        tick(1);
        check("bp_drop_valid", {31'd0, rx.rx_valid}, 32'd0);
        rx.rx_ready = 1'b1;

        // Reset in the middle of a frame
        burst(3); burst(2); burst(5);
        RST = 1'b1;
        tick(2);
        check("rst_mid_valid", {31'd0, rx.rx_valid}, 32'd0);
        check("rst_mid_data",  {16'd0, rx.rx_data},  32'd0);
        check("rst_mid_busy",  {31'd0, rx.rx_busy},  32'd0);
        check("rst_mid_err",   {31'd0, rx.rx_err},   32'd0);
        check("rst_mid_ovr",   {31'd0, rx.rx_ovr},   32'd0);
        RST = 1'b0;
        tick(4);
        snap();
        send_00fe();
        tick(4);
        check("rst_after_word", {16'd0, last_word}, 32'h00FE);
        check("rst_after_pulses", vrise - r0, 32'd1);

        // Idle partial frame
        snap();
        burst(3); burst(2); burst(5);
        tick(70);
`ifdef ECS_RX_TIMEOUT_EN
        check("to_err", err_seen - e0, 32'd1);
        check("to_busy", {31'd0, rx.rx_busy}, 32'd0);
        snap();
        send_00fe();
        tick(4);
        check("to_next_word", {16'd0, last_word}, 32'h00FE);
        check("to_next_pulses", vrise - r0, 32'd1);
`else
        check("noto_err", err_seen - e0, 32'd0);
        check("noto_busy", {31'd0, rx.rx_busy}, 32'd1);
        burst(3); burst(1); burst(2);
        tick(4);
        check("noto_word", {16'd0, last_word}, 32'h0312);
        check("noto_pulses", vrise - r0, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
